// File: rtl/shift_seq_ctrl_if.sv
// Command and register-drive bundle for shift_seq_ctrl.
// master = command source plus the register's Q feedback; slave = the controller.
interface shift_seq_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_fill;
    logic       cmd_dir;
    logic [3:0] q;
    logic       s1;
    logic       s0;
    logic [3:0] din;
    logic       dsr;
    logic       dsl;
    logic       busy;
    logic       done;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, cmd_dir, q,
        input  cmd_ready, s1, s0, din, dsr, dsl, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_data, cmd_fill, cmd_dir, q,
        output cmd_ready, s1, s0, din, dsr, dsl, busy, done
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register (LOAD / SHIFT / ROTATE).
// Define SHIFT_SEQ_ROTATE_EN to enable ROTATE; otherwise op 11 completes immediately.
module shift_seq_ctrl (
    input  logic             i_cp,
    input  logic             i_cr,
    shift_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic [1:0] r_sel;
    logic [3:0] r_din;
    logic       r_dsr;
    logic       r_dsl;
    logic       r_busy;
    logic       r_done;
    logic [2:0] w_cnt_sat;

    assign w_cnt_sat = (bus.cmd_cnt > 3'd4) ? 3'd4 : bus.cmd_cnt;

    // Gated by i_cr so the port drops the instant reset is asserted.
    assign bus.cmd_ready = (r_state == ST_IDLE) && !i_cr;
    assign bus.s1        = r_sel[1];
    assign bus.s0        = r_sel[0];
    assign bus.din       = r_din;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

`ifdef SHIFT_SEQ_ROTATE_EN
    logic r_rot_dn;
    logic r_rot_up;

    // Rotation feeds back the live register end bit every cycle.
    assign bus.dsr = r_rot_dn ? bus.q[0] : r_dsr;
    assign bus.dsl = r_rot_up ? bus.q[3] : r_dsl;
`else
    logic w_unused;
    assign w_unused = ^{bus.q, bus.cmd_dir};
    assign bus.dsr  = r_dsr;
    assign bus.dsl  = r_dsl;
`endif

    always_ff @(posedge i_cp or posedge i_cr) begin
        if (i_cr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_sel   <= 2'b00;
            r_din   <= 4'd0;
            r_dsr   <= 1'b0;
            r_dsl   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            r_rot_dn <= 1'b0;
            r_rot_up <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_busy <= 1'b1;
                        case (bus.cmd_op)
                            2'b00: begin
                                r_state <= ST_LOAD;
                                r_sel   <= 2'b11;
                                r_din   <= bus.cmd_data;
                            end
                            2'b01, 2'b10: begin
                                if (w_cnt_sat == 3'd0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    // Op encoding for the shifts equals the register mode select.
                                    r_state <= ST_SHIFT;
                                    r_cnt   <= w_cnt_sat;
                                    r_sel   <= bus.cmd_op;
                                    r_dsr   <= (bus.cmd_op == 2'b01) ? bus.cmd_fill : 1'b0;
                                    r_dsl   <= (bus.cmd_op == 2'b10) ? bus.cmd_fill : 1'b0;
                                end
                            end
                            default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                                if (w_cnt_sat == 3'd0) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state  <= ST_SHIFT;
                                    r_cnt    <= w_cnt_sat;
                                    r_sel    <= bus.cmd_dir ? 2'b10 : 2'b01;
                                    r_rot_up <= bus.cmd_dir;
                                    r_rot_dn <= !bus.cmd_dir;
                                end
`else
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DONE;
                    r_sel   <= 2'b00;
                    r_din   <= 4'd0;
                    r_done  <= 1'b1;
                end
                ST_SHIFT: begin
                    if (r_cnt == 3'd1) begin
                        r_state <= ST_DONE;
                        r_cnt   <= 3'd0;
                        r_sel   <= 2'b00;
                        r_dsr   <= 1'b0;
                        r_dsl   <= 1'b0;
                        r_done  <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
                        r_rot_dn <= 1'b0;
                        r_rot_up <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl driving a behavioural 4-bit universal shift register.
// Observation vector order: {s1,s0,din[3:0],dsr,dsl,busy,done,cmd_ready}.
module tb_shift_seq_ctrl;
    logic       clk;
    logic       rst;
    logic [3:0] q_reg;
    int         total = 0;
    int         bad   = 0;

    shift_seq_ctrl_if bus ();

    shift_seq_ctrl dut (
        .i_cp (clk),
        .i_cr (rst),
        .bus  (bus)
    );

    localparam logic [10:0] OBS_RST  = 11'b00_0000_00_000;
    localparam logic [10:0] OBS_IDLE = 11'b00_0000_00_001;
    localparam logic [10:0] OBS_DONE = 11'b00_0000_00_110;

    logic [10:0] obs;
    assign obs = {bus.s1, bus.s0, bus.din, bus.dsr, bus.dsl, bus.busy, bus.done, bus.cmd_ready};

    always_ff @(posedge clk) begin
        case ({bus.s1, bus.s0})
            2'b01:   q_reg <= {bus.dsr, q_reg[3:1]};
            2'b10:   q_reg <= {q_reg[2:0], bus.dsl};
            2'b11:   q_reg <= bus.din;
            default: q_reg <= q_reg;
        endcase
    end
    assign bus.q = q_reg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a command and return one step after the accepting edge; fields are scrambled afterwards.
    task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic fill, input logic dir);
        int n = 0;
        bus.cmd_op    = op;
        bus.cmd_cnt   = cnt;
        bus.cmd_data  = data;
        bus.cmd_fill  = fill;
        bus.cmd_dir   = dir;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        total++;
        if (!bus.cmd_ready) begin
            bad++;
            $display("FAIL accept_timeout ready=%b required=1", bus.cmd_ready);
        end
        step();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~data;
        bus.cmd_fill  = ~fill;
        bus.cmd_cnt   = 3'd3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00; bus.cmd_cnt = 3'd0; bus.cmd_data = 4'd0;
        bus.cmd_fill = 1'b0; bus.cmd_dir = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (obs !== OBS_RST) begin bad++; $display("FAIL reset_async obs=%b required=%b", obs, OBS_RST); end
        step();
        step();
        total++;
        if (obs !== OBS_RST) begin bad++; $display("FAIL reset_held obs=%b required=%b", obs, OBS_RST); end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== OBS_IDLE) begin bad++; $display("FAIL reset_release obs=%b required=%b", obs, OBS_IDLE); end
        step();
    endtask

    task automatic test_load();
        issue(2'b00, 3'd0, 4'b1010, 1'b0, 1'b0);
        total++;
        if (obs !== 11'b11_1010_00_100) begin bad++; $display("FAIL load_cycle obs=%b required=%b", obs, 11'b11_1010_00_100); end
        step();
        total++;
        if (obs !== OBS_DONE) begin bad++; $display("FAIL load_done obs=%b required=%b", obs, OBS_DONE); end
        total++;
        if (q_reg !== 4'b1010) begin bad++; $display("FAIL load_q q=%b required=1010", q_reg); end
        step();
        total++;
        if (obs !== OBS_IDLE) begin bad++; $display("FAIL load_idle obs=%b required=%b", obs, OBS_IDLE); end
    endtask

    task automatic test_shift_down();
        logic [3:0] exp_q [0:2];
        exp_q[0] = 4'b1010; exp_q[1] = 4'b1101; exp_q[2] = 4'b1110;
        issue(2'b01, 3'd2, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs !== 11'b01_0000_10_100 || q_reg !== exp_q[i]) begin
                bad++;
                $display("FAIL shift_down_c%0d obs=%b q=%b required=%b q=%b", i, obs, q_reg, 11'b01_0000_10_100, exp_q[i]);
            end
            step();
        end
        total++;
        if (obs !== OBS_DONE || q_reg !== exp_q[2]) begin
            bad++;
            $display("FAIL shift_down_done obs=%b q=%b required=%b q=%b", obs, q_reg, OBS_DONE, exp_q[2]);
        end
        step();
    endtask

    task automatic test_rotate_up();
        issue(2'b00, 3'd0, 4'b1001, 1'b0, 1'b0);
        issue(2'b11, 3'd7, 4'b0000, 1'b0, 1'b1);
`ifdef SHIFT_SEQ_ROTATE_EN
        begin
            logic [3:0] exp_q [0:3];
            logic [10:0] exp_obs;
            exp_q[0] = 4'b1001; exp_q[1] = 4'b0011; exp_q[2] = 4'b0110; exp_q[3] = 4'b1100;
            for (int i = 0; i < 4; i++) begin
                exp_obs = {2'b10, 4'b0000, 1'b0, exp_q[i][3], 3'b100};
                total++;
                if (obs !== exp_obs || q_reg !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rotate_c%0d obs=%b q=%b required=%b q=%b", i, obs, q_reg, exp_obs, exp_q[i]);
                end
                step();
            end
        end
`endif
        total++;
        if (obs !== OBS_DONE || q_reg !== 4'b1001) begin
            bad++;
            $display("FAIL rotate_done obs=%b q=%b required=%b q=1001", obs, q_reg, OBS_DONE);
        end
        step();
        total++;
        if (obs !== OBS_IDLE) begin bad++; $display("FAIL rotate_idle obs=%b required=%b", obs, OBS_IDLE); end
    endtask

    task automatic test_zero_count();
        issue(2'b10, 3'd0, 4'b0000, 1'b1, 1'b0);
        total++;
        if (obs !== OBS_DONE || q_reg !== 4'b1001) begin
            bad++;
            $display("FAIL zero_cnt_done obs=%b q=%b required=%b q=1001", obs, q_reg, OBS_DONE);
        end
        step();
        total++;
        if (obs !== OBS_IDLE || q_reg !== 4'b1001) begin
            bad++;
            $display("FAIL zero_cnt_idle obs=%b q=%b required=%b q=1001", obs, q_reg, OBS_IDLE);
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_q [0:2];
        exp_q[0] = 4'b1111; exp_q[1] = 4'b1110; exp_q[2] = 4'b1100;
        issue(2'b00, 3'd0, 4'b1111, 1'b0, 1'b0);
        issue(2'b10, 3'd4, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs !== 11'b10_0000_00_100 || q_reg !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_shift_c%0d obs=%b q=%b required=%b q=%b", i, obs, q_reg, 11'b10_0000_00_100, exp_q[i]);
            end
            if (i < 2) step();
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== OBS_RST || q_reg !== 4'b1100) begin
            bad++;
            $display("FAIL abort_immediate obs=%b q=%b required=%b q=1100", obs, q_reg, OBS_RST);
        end
        step();
        total++;
        if (obs !== OBS_RST || q_reg !== 4'b1100) begin
            bad++;
            $display("FAIL abort_held obs=%b q=%b required=%b q=1100", obs, q_reg, OBS_RST);
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== OBS_IDLE) begin bad++; $display("FAIL abort_release obs=%b required=%b", obs, OBS_IDLE); end
        step();
        total++;
        if (obs !== OBS_IDLE || q_reg !== 4'b1100) begin
            bad++;
            $display("FAIL abort_no_done obs=%b q=%b required=%b q=1100", obs, q_reg, OBS_IDLE);
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_ready [1:9];
        logic       exp_done  [1:9];
        logic [3:0] exp_q     [1:9];
        for (int i = 1; i <= 9; i++) begin
            exp_ready[i] = (i % 3 == 0);
            exp_done[i]  = (i % 3 == 2);
        end
        exp_q[2] = 4'b0011; exp_q[5] = 4'b1100; exp_q[8] = 4'b0011;
        exp_q[1] = 4'b0000; exp_q[3] = 4'b0000; exp_q[4] = 4'b0000;
        exp_q[6] = 4'b0000; exp_q[7] = 4'b0000; exp_q[9] = 4'b0000;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 4'b0011;
        bus.cmd_valid = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            total++;
            if (bus.cmd_ready !== exp_ready[i] || bus.done !== exp_done[i]) begin
                bad++;
                $display("FAIL b2b_e%0d ready=%b done=%b required ready=%b done=%b",
                         i, bus.cmd_ready, bus.done, exp_ready[i], exp_done[i]);
            end
            if (exp_done[i]) begin
                total++;
                if (q_reg !== exp_q[i]) begin
                    bad++;
                    $display("FAIL b2b_q_e%0d q=%b required=%b", i, q_reg, exp_q[i]);
                end
            end
            if (bus.cmd_ready) bus.cmd_data = ~bus.cmd_data;
        end
        bus.cmd_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_down();
        test_rotate_up();
        test_zero_count();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 CP  input  1  clock; all state updates on rising edge.
REQ-002 CR  input  1  reset, asynchronous, active-high.
REQ-003 CMD_VALID  input  1  command offered this cycle.
REQ-004 CMD_READY  output  1  controller can accept a command; high only in IDLE with CR low.
REQ-005 CMD_OP  input  2  00 LOAD, 01 SHIFT-DOWN (toward Q[0]), 10 SHIFT-UP (toward Q[3]), 11 ROTATE.
REQ-006 CMD_CNT  input  3  shift/rotate step count; 0 means no steps, 5..7 saturate to 4.
REQ-007 CMD_DATA  input  4  parallel word for LOAD.
REQ-008 CMD_FILL  input  1  serial fill bit for SHIFT-DOWN/SHIFT-UP.
REQ-009 CMD_DIR  input  1  ROTATE direction: 0 down, 1 up.
REQ-010 Q  input  4  current contents of the driven 4-bit universal shift register.
REQ-011 S1, S0  output  1 each  mode select to the register: 00 hold, 01 Q<={Dsr,Q[3:1]}, 10 Q<={Q[2:0],Dsl}, 11 Q<=Din.
REQ-012 Din  output  4  parallel load data to the register.
REQ-013 Dsr, Dsl  output  1 each  serial inputs to the register.
REQ-014 BUSY  output  1  high in LOAD, SHIFT or DONE states.
REQ-015 DONE  output  1  one-cycle pulse when a command completes.

Function
REQ-016 FSM states IDLE, LOAD, SHIFT, DONE; the register and the controller share CP.
REQ-017 Accept occurs on a rising edge with CMD_VALID=1 and CMD_READY=1; all CMD_* fields are latched there and ignored afterwards.
REQ-018 IDLE -> LOAD on accepted LOAD; IDLE -> SHIFT on accepted SHIFT/ROTATE with saturated count >= 1; IDLE -> DONE on accepted SHIFT/ROTATE with count 0.
REQ-019 LOAD lasts exactly one cycle: {S1,S0}=11, Din=latched data; next state DONE.
REQ-020 SHIFT lasts exactly N cycles (N = saturated count); a down-counter decrements each cycle; leave to DONE when the counter reaches 1.
REQ-021 SHIFT-DOWN drives 01 with Dsr=latched fill; SHIFT-UP drives 10 with Dsl=latched fill.
REQ-022 ROTATE down drives 01 with Dsr=Q[0]; ROTATE up drives 10 with Dsl=Q[3]; feedback is combinational from Q each cycle.
REQ-023 DONE lasts one cycle: {S1,S0}=00, DONE=1, CMD_READY=0; next state IDLE.
REQ-024 IDLE and DONE drive {S1,S0}=00; Din, Dsl, Dsr are 0 whenever not in use.
REQ-025 Command latency: LOAD completes in 2 cycles after accept, SHIFT/ROTATE in N+1 cycles; back-to-back accept is possible on the edge after DONE.
REQ-026 CMD_VALID while CMD_READY=0 has no effect; no command is queued.

Reset
REQ-027 CR=1 immediately forces IDLE, counter=0, latched fields=0, {S1,S0}=00, Din=0, Dsl=Dsr=0, BUSY=0, DONE=0, CMD_READY=0.
REQ-028 CR asserted mid-command aborts it with no DONE pulse; after CR falls, CMD_READY=1 from the first cycle.

Configuration
REQ-029 Macro SHIFT_SEQ_ROTATE_EN defined: ROTATE behaves per REQ-022.
REQ-030 Macro SHIFT_SEQ_ROTATE_EN undefined: op 11 is accepted, goes directly to DONE, drives {S1,S0}=00 throughout, register unchanged.

Verification
REQ-031 Reset, then LOAD CMD_DATA=1010 -> one cycle S=11 Din=1010, DONE next cycle, register Q=1010.
REQ-032 Q=1010, SHIFT-DOWN CNT=2 FILL=1 -> two cycles S=01 Dsr=1, Q=1101 then 1110 after, DONE at accept+3.
REQ-033 Q=1001, ROTATE up CNT=7 (sat 4), ROTATE enabled -> four cycles S=10, Q returns to 1001, DONE at accept+5; with macro undefined -> DONE at accept+1, Q=1001.
REQ-034 SHIFT-UP CNT=0 -> no S=10 cycle, DONE on cycle after accept, Q unchanged.
REQ-035 Start SHIFT-UP CNT=4 FILL=0 from Q=1111, assert CR after 2 shift cycles -> outputs zero immediately, no DONE, CMD_READY=1 the first cycle after release.
REQ-036 Hold CMD_VALID=1 with alternating LOADs 0011/1100 -> accepts only in IDLE, one accept every 3 cycles, Q sequence 0011, 1100.
